// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO with valid/ready on both sides.
// Wrap-bit pointers distinguish full from empty; flush_i clears synchronously.
module stream_fifo #(
    parameter int Depth     = 8,
    parameter int WordWidth = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enq_vld_i,
    input  logic [WordWidth-1:0] enq_payload_i,
    output logic                 enq_rdy_o,
    output logic                 deq_vld_o,
    output logic [WordWidth-1:0] deq_payload_o,
    input  logic                 deq_rdy_i,
    input  logic                 flush_i
);

    localparam int AddrW = $clog2(Depth);
    localparam int PtrW  = AddrW + 1;

    logic [WordWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AddrW-1:0]     wr_idx_s, rd_idx_s;
    logic                 full_s, empty_s;
    logic                 enq_fire_s, deq_fire_s;
    logic                 mem_we_s;

    assign wr_idx_s = wr_ptr_q[AddrW-1:0];
    assign rd_idx_s = rd_ptr_q[AddrW-1:0];

    // Full/empty come only from registered pointers, so enq_rdy_o never sees deq_rdy_i.
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_idx_s == rd_idx_s) && (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);

    assign enq_rdy_o     = ~full_s;
    assign deq_vld_o     = ~empty_s;
    assign deq_payload_o = mem_q[rd_idx_s];

    assign enq_fire_s = enq_vld_i & ~full_s;
    assign deq_fire_s = deq_rdy_i & ~empty_s;

    // Next-state pointers; flush overrides any handshake in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_we_s = 1'b0;
        if (flush_i) begin
            wr_ptr_d = {PtrW{1'b0}};
            rd_ptr_d = {PtrW{1'b0}};
        end else begin
            if (enq_fire_s) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
                mem_we_s = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (deq_fire_s) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= {PtrW{1'b0}};
            rd_ptr_q <= {PtrW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents deliberately left unreset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[wr_idx_s] <= enq_payload_i;
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Scoreboard bench for stream_fifo: a reference queue tracks expected contents.
module tb_stream_fifo;

    localparam int Depth = 8;
    localparam int W     = 64;

    logic         clk = 1'b0;
    logic         rstn;
    logic         enq_vld_i;
    logic [W-1:0] enq_payload_i;
    logic         enq_rdy_o;
    logic         deq_vld_o;
    logic [W-1:0] deq_payload_o;
    logic         deq_rdy_i;
    logic         flush_i;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] sb_q[$];

    stream_fifo #(.Depth(Depth), .WordWidth(W)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .enq_vld_i     (enq_vld_i),
        .enq_payload_i (enq_payload_i),
        .enq_rdy_o     (enq_rdy_o),
        .deq_vld_o     (deq_vld_o),
        .deq_payload_o (deq_payload_o),
        .deq_rdy_i     (deq_rdy_i),
        .flush_i       (flush_i)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, update the model.
    task automatic cycle(input logic ev, input logic [W-1:0] ep, input logic dr, input logic fl);
        bit can_enq;
        @(negedge clk);
        enq_vld_i     = ev;
        enq_payload_i = ep;
        deq_rdy_i     = dr;
        flush_i       = fl;
        #1;
        check_eq("deq_vld", {63'd0, deq_vld_o}, {63'd0, (sb_q.size() != 0)});
        check_eq("enq_rdy", {63'd0, enq_rdy_o}, {63'd0, (sb_q.size() < Depth)});
        can_enq = (sb_q.size() < Depth);
        if (fl) begin
            sb_q.delete();
        end else begin
            if (dr && sb_q.size() != 0) begin
                check_eq("deq_data", deq_payload_o, sb_q[0]);
                void'(sb_q.pop_front());
            end
            if (ev && can_enq) sb_q.push_back(ep);
        end
    endtask

    initial begin
        logic [W-1:0] pl;
        rstn = 1'b0; enq_vld_i = 1'b0; enq_payload_i = '0; deq_rdy_i = 1'b0; flush_i = 1'b0;
        #12;
        check_eq("rst_vld", {63'd0, deq_vld_o}, 64'd0);
        check_eq("rst_rdy", {63'd0, enq_rdy_o}, 64'd1);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 64'd0, 1'b0, 1'b0);

        // Fill to full, then a ninth offer that must be refused.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 64'(i), 1'b0, 1'b0);
        cycle(1'b1, 64'h9, 1'b0, 1'b0);
        cycle(1'b1, 64'h9, 1'b1, 1'b0);   // full + dequeue: write still refused
        for (int i = 0; i < 9; i++) cycle(1'b0, 64'd0, 1'b1, 1'b0);

        // Steady occupancy of 3 with simultaneous traffic across wraps.
        for (int i = 0; i < 3; i++) cycle(1'b1, 64'(100 + i), 1'b0, 1'b0);
        for (int i = 3; i < 23; i++) begin
            cycle(1'b1, 64'(100 + i), 1'b1, 1'b0);
            check_eq("occupancy", 64'(sb_q.size()), 64'd3);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 64'd0, 1'b1, 1'b0);

        // Flush with a concurrent enqueue that must be dropped.
        for (int i = 0; i < 5; i++) cycle(1'b1, 64'(200 + i), 1'b0, 1'b0);
        cycle(1'b1, 64'hAA, 1'b1, 1'b1);
        cycle(1'b1, 64'hBB, 1'b0, 1'b0);
        cycle(1'b0, 64'd0, 1'b1, 1'b0);
        cycle(1'b0, 64'd0, 1'b0, 1'b0);

        // Asynchronous reset mid-operation discards contents immediately.
        for (int i = 0; i < 4; i++) cycle(1'b1, 64'(300 + i), 1'b0, 1'b0);
        @(negedge clk);
        enq_vld_i = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check_eq("arst_vld", {63'd0, deq_vld_o}, 64'd0);
        check_eq("arst_rdy", {63'd0, enq_rdy_o}, 64'd1);
        sb_q.delete();
        @(posedge clk);
        #1 rstn = 1'b1;
        cycle(1'b0, 64'd0, 1'b1, 1'b0);

        // Random traffic against the reference queue.
        for (int i = 0; i < 20000; i++) begin
            pl = {$urandom, $urandom};
            cycle(1'($urandom_range(0, 1)), pl, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 499) == 0));
        end
        while (sb_q.size() != 0) cycle(1'b0, 64'd0, 1'b1, 1'b0);
        cycle(1'b0, 64'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
